// File: rtl/rr_stream_mux_if.sv
// rtl/rr_stream_mux_if.sv - handshake bundle for rr_stream_mux
interface rr_stream_mux_if #(
   parameter int W    = 8,
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
);
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic            mode;
   logic [SELW-1:0] sel;
   logic [W-1:0]    out_data;
   logic [SELW-1:0] out_chan;
   logic            out_valid;
   logic            out_ready;
   logic            err;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid, err
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid, err
   );
endinterface

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel registered stream mux, external select or round-robin
module rr_stream_mux #(
   parameter int W    = 8,
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_stream_mux_if.slave bus
);
   logic [W-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0] out_chan_q, out_chan_d;
   logic            out_valid_q, out_valid_d;
   logic            err_q, err_d;
   logic [SELW-1:0] ptr_q, ptr_d;

   logic [N-1:0]    grant;
   logic [SELW-1:0] chan_sel;
   logic [W-1:0]    data_sel;
   logic            load_en;
   logic            xfer;

   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      if (!bus.mode) begin
         if (int'(bus.sel) < N && ((bus.in_valid >> bus.sel) & N'(1)) != '0)
            grant = N'(1) << bus.sel;
      end else begin
         // Scan from ptr upward, wrapping, and take the first requester.
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N)
               idx = idx - N;
            if (!found && ((bus.in_valid >> idx) & N'(1)) != '0) begin
               found = 1'b1;
               grant = N'(1) << idx;
            end
         end
      end
   end

   always_comb begin
      chan_sel = '0;
      data_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            chan_sel = SELW'(i);
            data_sel = W'(bus.in_data >> (i * W));
         end
      end
   end

   always_comb begin
      load_en      = !out_valid_q || bus.out_ready;
      xfer         = load_en && (grant != '0);
      out_valid_d  = load_en ? xfer : out_valid_q;
      out_data_d   = xfer ? data_sel : out_data_q;
      out_chan_d   = xfer ? chan_sel : out_chan_q;
      ptr_d        = ptr_q;
      if (xfer && bus.mode)
         ptr_d = (int'(chan_sel) == N - 1) ? '0 : SELW'(int'(chan_sel) + 1);
      err_d        = !bus.mode && (int'(bus.sel) >= N) && load_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         ptr_q       <= ptr_d;
      end
   end

   // Gated by rst_n so nothing is accepted while the output stage is held in reset.
   assign bus.in_ready  = (load_en && rst_n) ? grant : '0;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_valid = out_valid_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - scoreboard bench for rr_stream_mux
module tb_rr_stream_mux;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [31:0] exp_q[$];

   rr_stream_mux_if #(.W(8), .N(4), .SELW(2)) a();
   rr_stream_mux_if #(.W(8), .N(3), .SELW(2)) b();

   rr_stream_mux #(.W(8), .N(4), .SELW(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   rr_stream_mux #(.W(8), .N(3), .SELW(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int chan, input logic [7:0] data);
      exp_q.push_back({16'h0, 8'(chan), data});
   endtask

   // Monitor: every accepted output word is compared against the scoreboard head.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && a.out_valid && a.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {a.out_chan, a.out_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("out_chan", 32'(a.out_chan), 32'(e[15:8]));
            check("out_data", 32'(a.out_data), 32'(e[7:0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] words [4];
      words[0] = 8'hA0; words[1] = 8'hB1; words[2] = 8'hC2; words[3] = 8'hD3;

      rst_n = 1'b0;
      a.in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      a.in_valid = 4'hF; a.mode = 1'b1; a.sel = 2'd0; a.out_ready = 1'b0;
      b.in_data = 24'h332211; b.in_valid = 3'b000; b.mode = 1'b0; b.sel = 2'd0; b.out_ready = 1'b0;
      repeat (2) tick();
      check("rst_out_valid", 32'(a.out_valid), 0);
      check("rst_out_data", 32'(a.out_data), 0);
      check("rst_out_chan", 32'(a.out_chan), 0);
      check("rst_err", 32'(a.err), 0);
      check("rst_in_ready", 32'(a.in_ready), 0);

      // Select mode stepping sel 0..3
      a.mode = 1'b0; a.out_ready = 1'b1;
      rst_n = 1'b1;
      for (int s = 0; s < 4; s++) begin
         a.sel = 2'(s);
         #1;
         check("sel_in_ready", 32'(a.in_ready), 32'(1 << s));
         push(s, words[s]);
         tick();
      end
      a.in_valid = 4'h0;
      tick();
      check("drain_out_valid", 32'(a.out_valid), 0);
      check("drain_out_data_hold", 32'(a.out_data), 32'hD3);

      // Round-robin fairness, all valid then 1001
      a.mode = 1'b1; a.in_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         push(k % 4, words[k % 4]);
         tick();
      end
      a.in_valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         push((k % 2) ? 3 : 0, words[(k % 2) ? 3 : 0]);
         tick();
      end
      a.in_valid = 4'h0;
      tick();
      check("rr_drain_valid", 32'(a.out_valid), 0);

      // Backpressure
      a.mode = 1'b0; a.sel = 2'd1; a.in_valid = 4'b0010; a.out_ready = 1'b0;
      tick();
      a.in_valid = 4'b0100; a.sel = 2'd2;
      for (int k = 0; k < 3; k++) begin
         check("bp_out_valid", 32'(a.out_valid), 1);
         check("bp_out_data", 32'(a.out_data), 32'hB1);
         check("bp_out_chan", 32'(a.out_chan), 1);
         check("bp_in_ready", 32'(a.in_ready), 0);
         tick();
      end
      a.out_ready = 1'b1; a.mode = 1'b1;
      push(1, 8'hB1);
      push(2, 8'hC2);
      #1;
      check("bp_release_in_ready", 32'(a.in_ready), 32'b0100);
      tick();
      check("bp_reload_valid", 32'(a.out_valid), 1);
      a.in_valid = 4'h0;
      tick();

      // Reset mid-stream with a held word; ptr is 3 here and must return to 0
      a.out_ready = 1'b0; a.mode = 1'b0; a.sel = 2'd3; a.in_valid = 4'b1000;
      tick();
      a.in_valid = 4'h0;
      check("held_before_reset", 32'(a.out_valid), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(a.out_valid), 0);
      check("midrst_out_data", 32'(a.out_data), 0);
      check("midrst_out_chan", 32'(a.out_chan), 0);
      check("midrst_err", 32'(a.err), 0);
      tick();
      rst_n = 1'b1;
      a.mode = 1'b1; a.in_valid = 4'b1010; a.out_ready = 1'b1;
      push(1, 8'hB1);
      tick();
      a.in_valid = 4'h0;
      tick();

      // Out-of-range select on the N=3 instance
      b.mode = 1'b0; b.sel = 2'd3; b.in_valid = 3'b111; b.out_ready = 1'b1;
      #1;
      check("oor_in_ready", 32'(b.in_ready), 0);
      check("oor_err_before", 32'(b.err), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("oor_err", 32'(b.err), 1);
         check("oor_out_valid", 32'(b.out_valid), 0);
      end
      b.sel = 2'd2;
      tick();
      check("oor_err_clear", 32'(b.err), 0);
      check("oor_inrange_load", 32'(b.out_chan), 2);
      check("oor_inrange_data", 32'(b.out_data), 32'h33);
      b.in_valid = 3'b000;
      tick();

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
